// File: rtl/ps2_pkg.sv
// Shared constants, transmit state codes and timing helpers for the PS/2 host controller.
package ps2_pkg;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned FRAME_BITS    = 11;
    localparam int unsigned TX_EDGES      = 10;   // device falling edges from d0 through stop
    localparam int unsigned RX_TIMEOUT_US = 2000;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t TX_IDLE     = 3'd0;
    localparam tx_state_t TX_INHIBIT  = 3'd1;
    localparam tx_state_t TX_START    = 3'd2;
    localparam tx_state_t TX_WAIT_CLK = 3'd3;
    localparam tx_state_t TX_SHIFT    = 3'd4;
    localparam tx_state_t TX_WAIT_ACK = 3'd5;
    localparam tx_state_t TX_DONE     = 3'd6;
    localparam tx_state_t TX_TIMEOUT  = 3'd7;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        logic [63:0] cyc;
        cyc = (64'(clk_hz) * 64'(us)) / 64'd1_000_000;
        if (cyc == 64'd0) cyc = 64'd1;
        return 32'(cyc);
    endfunction

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_controller_if.sv
// Host-side command/receive bundle between the PS/2 controller and its peripheral wrapper.
interface ps2_controller_if;
    import ps2_pkg::*;

    logic [DATA_BITS-1:0] the_command;
    logic                 send_command;
    logic [DATA_BITS-1:0] received_data;
    logic                 received_data_en;
    logic                 command_was_sent;
    logic                 error_communication_timed_out;

    modport master (
        output the_command, send_command,
        input  received_data, received_data_en, command_was_sent, error_communication_timed_out
    );

    modport slave (
        input  the_command, send_command,
        output received_data, received_data_en, command_was_sent, error_communication_timed_out
    );
endinterface

// File: rtl/ps2_command_out.sv
// Host-to-device transmit FSM: request (inhibit + start), bit shifting on device clocks, ACK wait.
//   state       | meaning
//   TX_IDLE     | waiting for send_command with no receive frame in progress
//   TX_INHIBIT  | CLK held low for the inhibit time
//   TX_START    | DAT low (start bit), CLK released
//   TX_WAIT_CLK | waiting for the device's first falling clock edge
//   TX_SHIFT    | presenting d1..d7, parity, stop after each device falling edge
//   TX_WAIT_ACK | waiting for DAT low on a falling edge, then both lines high
//   TX_DONE     | command_was_sent until send_command drops
//   TX_TIMEOUT  | timeout flag until send_command drops, pins released
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ        = 50_000_000,
    parameter int unsigned INHIBIT_US         = 100,
    parameter int unsigned DEV_CLK_TIMEOUT_US = 15000,
    parameter int unsigned TX_TIMEOUT_US      = 2000,
    parameter int unsigned ACK_TIMEOUT_US     = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send_command,
    input  logic [DATA_BITS-1:0] the_command,
    input  logic                 rx_busy,
    input  logic                 clk_fall,
    input  logic                 clk_s,
    input  logic                 dat_s,
    output logic                 clk_low,
    output logic                 dat_low,
    output logic                 tx_idle,
    output logic                 command_was_sent,
    output logic                 timed_out
);

    localparam int unsigned INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned DEV_CYC = us_to_cycles(CLK_FREQ_HZ, DEV_CLK_TIMEOUT_US);
    localparam int unsigned TX_CYC  = us_to_cycles(CLK_FREQ_HZ, TX_TIMEOUT_US);
    localparam int unsigned ACK_CYC = us_to_cycles(CLK_FREQ_HZ, ACK_TIMEOUT_US);
    localparam int unsigned MAX_A   = (INH_CYC > DEV_CYC) ? INH_CYC : DEV_CYC;
    localparam int unsigned MAX_B   = (TX_CYC > ACK_CYC) ? TX_CYC : ACK_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] INH_LOAD = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] DEV_LOAD = TW'(DEV_CYC - 1);
    localparam logic [TW-1:0] TX_LOAD  = TW'(TX_CYC - 1);
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_CYC - 1);

    tx_state_t          state;
    logic [TW-1:0]      timer;
    logic [DATA_BITS:0] sh;
    logic [3:0]         edges;
    logic               ack_seen;

    assign tx_idle          = (state == TX_IDLE);
    assign command_was_sent = (state == TX_DONE);
    assign timed_out        = (state == TX_TIMEOUT);

    // The shift register refills with 1s, so the edge after parity releases DAT as the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            timer    <= '0;
            sh       <= '0;
            edges    <= '0;
            ack_seen <= 1'b0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: if (send_command && !rx_busy) begin
                    sh      <= {odd_parity(the_command), the_command};
                    clk_low <= 1'b1;
                    timer   <= INH_LOAD;
                    state   <= TX_INHIBIT;
                end
                TX_INHIBIT: if (timer == '0) begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b1;
                    state   <= TX_START;
                end else begin
                    timer <= timer - 1'b1;
                end
                TX_START: begin
                    timer <= DEV_LOAD;
                    state <= TX_WAIT_CLK;
                end
                TX_WAIT_CLK: if (clk_fall) begin
                    dat_low <= ~sh[0];
                    sh      <= {1'b1, sh[DATA_BITS:1]};
                    edges   <= 4'd1;
                    timer   <= TX_LOAD;
                    state   <= TX_SHIFT;
                end else if (timer == '0) begin
                    dat_low <= 1'b0;
                    state   <= TX_TIMEOUT;
                end else begin
                    timer <= timer - 1'b1;
                end
                TX_SHIFT: if (timer == '0) begin
                    dat_low <= 1'b0;
                    state   <= TX_TIMEOUT;
                end else if (clk_fall) begin
                    dat_low <= ~sh[0];
                    sh      <= {1'b1, sh[DATA_BITS:1]};
                    edges   <= edges + 4'd1;
                    if (edges == 4'(TX_EDGES - 1)) begin
                        timer    <= ACK_LOAD;
                        ack_seen <= 1'b0;
                        state    <= TX_WAIT_ACK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end else begin
                    timer <= timer - 1'b1;
                end
                TX_WAIT_ACK: if (timer == '0) begin
                    state <= TX_TIMEOUT;
                end else begin
                    timer <= timer - 1'b1;
                    if (clk_fall && !dat_s) ack_seen <= 1'b1;
                    if (ack_seen && clk_s && dat_s) state <= TX_DONE;
                end
                TX_DONE, TX_TIMEOUT: if (!send_command) state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_controller.sv
// PS/2 host link: pin synchronisers, receive shifter with frame checks, and the transmit FSM.
module ps2_controller
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ        = 50_000_000,
    parameter int unsigned INHIBIT_US         = 100,
    parameter int unsigned DEV_CLK_TIMEOUT_US = 15000,
    parameter int unsigned TX_TIMEOUT_US      = 2000,
    parameter int unsigned ACK_TIMEOUT_US     = 1000
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    inout  wire              PS2_CLK,
    inout  wire              PS2_DAT,
    ps2_controller_if.slave  bus
);

    localparam int unsigned RX_CYC  = us_to_cycles(CLK_FREQ_HZ, RX_TIMEOUT_US);
    localparam int          RW      = $clog2(RX_CYC + 1);
    localparam logic [RW-1:0] RX_LOAD = RW'(RX_CYC - 1);

    logic [2:0]         clk_sync;
    logic [1:0]         dat_sync;
    logic               clk_s, dat_s, clk_fall;
    logic               clk_low, dat_low, tx_idle;
    logic               rx_active;
    logic [3:0]         rx_count;
    logic [DATA_BITS:0] rx_sh;
    logic [RW-1:0]      rx_timer;
    logic [DATA_BITS+1:0] frame;

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    // Idle-high reset values keep a released bus from looking like a falling edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign clk_fall = clk_sync[2] & ~clk_sync[1];
    assign frame    = {dat_s, rx_sh};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_active             <= 1'b0;
            rx_count              <= '0;
            rx_sh                 <= '0;
            rx_timer              <= '0;
            bus.received_data     <= '0;
            bus.received_data_en  <= 1'b0;
        end else begin
            bus.received_data_en <= 1'b0;
            if (!tx_idle) begin
                rx_active <= 1'b0;
            end else if (!rx_active) begin
                if (clk_fall && !dat_s) begin
                    rx_active <= 1'b1;
                    rx_count  <= '0;
                    rx_timer  <= RX_LOAD;
                end
            end else if (clk_fall) begin
                rx_timer <= RX_LOAD;
                if (rx_count == 4'(FRAME_BITS - 2)) begin
                    rx_active <= 1'b0;
                    if (frame[DATA_BITS+1] && ^frame[DATA_BITS:0]) begin
                        bus.received_data    <= frame[DATA_BITS-1:0];
                        bus.received_data_en <= 1'b1;
                    end
                end else begin
                    rx_sh    <= {dat_s, rx_sh[DATA_BITS:1]};
                    rx_count <= rx_count + 4'd1;
                end
            end else if (rx_timer == '0) begin
                rx_active <= 1'b0;
            end else begin
                rx_timer <= rx_timer - 1'b1;
            end
        end
    end

    ps2_command_out #(
        .CLK_FREQ_HZ        (CLK_FREQ_HZ),
        .INHIBIT_US         (INHIBIT_US),
        .DEV_CLK_TIMEOUT_US (DEV_CLK_TIMEOUT_US),
        .TX_TIMEOUT_US      (TX_TIMEOUT_US),
        .ACK_TIMEOUT_US     (ACK_TIMEOUT_US)
    ) u_command_out (
        .clk              (CLOCK_50),
        .rst_n            (reset_n),
        .send_command     (bus.send_command),
        .the_command      (bus.the_command),
        .rx_busy          (rx_active),
        .clk_fall         (clk_fall),
        .clk_s            (clk_s),
        .dat_s            (dat_s),
        .clk_low          (clk_low),
        .dat_low          (dat_low),
        .tx_idle          (tx_idle),
        .command_was_sent (bus.command_was_sent),
        .timed_out        (bus.error_communication_timed_out)
    );

endmodule

// File: tb/tb_ps2_controller.sv
// Bench for ps2_controller: open-collector device model, scoreboard queues and a negedge monitor.
module tb_ps2_controller;

    localparam int unsigned CLK_HZ  = 1_000_000;   // 1 us per cycle keeps timeouts short
    localparam int unsigned INH_US  = 100;
    localparam int unsigned DEV_US  = 3000;
    localparam int unsigned TXT_US  = 2000;
    localparam int unsigned ACK_US  = 1000;
    localparam int          INH_CYC = INH_US * (CLK_HZ / 1_000_000);
    localparam int          HP      = 40;          // device half period, 12.5 kHz

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk, ps2_dat;

    pullup pu_clk (ps2_clk);
    pullup pu_dat (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_controller_if bus ();

    ps2_controller #(
        .CLK_FREQ_HZ        (CLK_HZ),
        .INHIBIT_US         (INH_US),
        .DEV_CLK_TIMEOUT_US (DEV_US),
        .TX_TIMEOUT_US      (TXT_US),
        .ACK_TIMEOUT_US     (ACK_US)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_rx[$];
    logic [9:0] exp_cmd[$];
    logic [9:0] got_cmd[$];
    bit         exp_tx[$];      // 1 = timeout expected, 0 = command sent
    logic prev_sent = 1'b0;
    logic prev_to   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        vectors++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected", name, got);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.received_data_en) begin
                if (exp_rx.size() == 0) unexpected("rx_spurious_en", 32'(bus.received_data));
                else check("rx_data", 32'(bus.received_data), 32'(exp_rx.pop_front()));
            end
            if (bus.command_was_sent && !prev_sent) begin
                if (exp_tx.size() == 0) unexpected("tx_spurious_sent", 32'd0);
                else check("tx_outcome", 32'd0, 32'(exp_tx.pop_front()));
            end
            if (bus.error_communication_timed_out && !prev_to) begin
                if (exp_tx.size() == 0) unexpected("tx_spurious_timeout", 32'd1);
                else check("tx_outcome", 32'd1, 32'(exp_tx.pop_front()));
            end
            if (got_cmd.size() > 0) begin
                if (exp_cmd.size() == 0) unexpected("tx_bits_spurious", 32'(got_cmd.pop_front()));
                else check("tx_bits", 32'(got_cmd.pop_front()), 32'(exp_cmd.pop_front()));
            end
        end
        prev_sent = bus.command_was_sent;
        prev_to   = bus.error_communication_timed_out;
    end

    task automatic dev_bit(input logic b);
        dev_dat_low = ~b;
        cyc(HP / 2);
        dev_clk_low = 1'b1;
        cyc(HP);
        dev_clk_low = 1'b0;
        cyc(HP / 2);
    endtask

    task automatic dev_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] f;
        logic good_par;
        good_par = ($countones(d) % 2 == 0);
        f = {stop, par, d, 1'b0};
        if (stop && (par == good_par)) exp_rx.push_back(d);
        for (int i = 0; i < 11; i++) dev_bit(f[i]);
        dev_dat_low = 1'b0;
        cyc(HP);
    endtask

    task automatic dev_partial(input logic [7:0] d);
        logic [10:0] f;
        f = {2'b11, d, 1'b0};
        for (int i = 0; i < 4; i++) dev_bit(f[i]);
        dev_dat_low = 1'b0;
        cyc(2600);
    endtask

    // mode 0: full ACK, 1: device never clocks, 2: clocks but no ACK, 3: reset mid-shift
    task automatic host_cmd(input logic [7:0] c, input int mode);
        int n;
        int nclk;
        logic [9:0] got;
        logic p;
        p = ($countones(c) % 2 == 0);
        got = '0;
        bus.the_command = c;
        bus.send_command = 1'b1;
        if (mode == 0 || mode == 2) exp_cmd.push_back({1'b1, p, c});
        if (mode == 0) exp_tx.push_back(1'b0);
        if (mode == 1 || mode == 2) exp_tx.push_back(1'b1);
        n = 0;
        while (ps2_clk !== 1'b0 && n < 50) begin cyc(1); n++; end
        check("tx_inhibit_seen", 32'(ps2_clk), 32'd0);
        n = 0;
        while (ps2_clk === 1'b0 && n < 1000) begin cyc(1); n++; end
        check("tx_inhibit_len_ok", 32'(n >= INH_CYC && n < 1000), 32'd1);
        cyc(2);
        check("tx_start_bit", 32'(ps2_dat), 32'd0);
        if (mode != 1) begin
            nclk = (mode == 3) ? 4 : 10;
            for (int k = 0; k < nclk; k++) begin
                cyc(HP / 2);
                dev_clk_low = 1'b1;
                cyc(HP);
                got[k] = ps2_dat;
                dev_clk_low = 1'b0;
                cyc(HP / 2);
            end
            if (mode == 3) begin
                reset_n = 1'b0;
                #1;
                check("rst_mid_pins", 32'({ps2_clk, ps2_dat}), 32'b11);
                check("rst_mid_outputs", 32'({bus.received_data_en, bus.command_was_sent,
                      bus.error_communication_timed_out, bus.received_data}), 32'd0);
                bus.send_command = 1'b0;
                cyc(5);
                reset_n = 1'b1;
                cyc(20);
                return;
            end
            got_cmd.push_back(got);
            if (mode == 0) begin
                cyc(HP / 2);
                dev_dat_low = 1'b1;
                cyc(HP / 2);
                dev_clk_low = 1'b1;
                cyc(HP);
                dev_clk_low = 1'b0;
                cyc(HP / 2);
                dev_dat_low = 1'b0;
            end
        end
        n = 0;
        while (!(bus.command_was_sent || bus.error_communication_timed_out) && n < 5000) begin
            cyc(1);
            n++;
        end
        check("tx_flag_in_time", 32'(n < 5000), 32'd1);
        cyc(20);
        check("tx_sent_held", 32'(bus.command_was_sent), 32'(mode == 0));
        check("tx_timeout_held", 32'(bus.error_communication_timed_out), 32'(mode != 0));
        check("tx_pins_released", 32'({ps2_clk, ps2_dat}), 32'b11);
        bus.send_command = 1'b0;
        cyc(3);
        check("tx_flags_clear", 32'({bus.command_was_sent, bus.error_communication_timed_out}), 32'd0);
        cyc(50);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, %0d vectors so far", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic good;
        int r;
        bus.the_command = 8'h00;
        bus.send_command = 1'b0;
        cyc(5);
        check("reset_outputs", 32'({bus.received_data_en, bus.command_was_sent,
              bus.error_communication_timed_out, bus.received_data}), 32'd0);
        check("reset_pins", 32'({ps2_clk, ps2_dat}), 32'b11);
        reset_n = 1'b1;
        cyc(10);

        dev_frame(8'hFA, 1'b1, 1'b1);
        dev_frame(8'h08, 1'b1, 1'b1);
        cyc(10);
        check("rx_hold_after_bad", 32'(bus.received_data), 32'hFA);

        dev_partial(8'h3C);
        dev_frame(8'hA5, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            good = ($countones(d) % 2 == 0);
            r = int'($urandom_range(0, 7));
            dev_frame(d, good ^ (r == 0), r != 1);
        end

        host_cmd(8'hF4, 0);
        host_cmd(8'hFF, 1);
        host_cmd(8'($urandom), 2);
        host_cmd(8'hED, 3);
        host_cmd(8'hF4, 0);
        host_cmd(8'($urandom), 0);
        dev_frame(8'hFA, 1'b1, 1'b1);
        cyc(20);

        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ps2_controller.md
Name: ps2_controller

Overview:
PS/2 host-side link controller for a keyboard or mouse.
- Receives 11-bit device frames and presents each data byte with a one-cycle strobe.
- Transmits host command bytes using the PS/2 host-to-device request/ACK protocol, with timeouts.
- Sits under peripheral wrappers (e.g. the mouse register device) and drives the open-collector PS2_CLK/PS2_DAT pins directly.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; every timing count below derives from it.
INHIBIT_US, 100, time the host holds CLK low before issuing the start bit.
DEV_CLK_TIMEOUT_US, 15000, maximum wait for the device's first clock after the request.
TX_TIMEOUT_US, 2000, maximum time to shift out data, parity and stop.
ACK_TIMEOUT_US, 1000, maximum wait for the device ACK.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
the_command  input  8  command byte to transmit.
send_command  input  1  level request to transmit the_command.
PS2_CLK  inout  1  open-collector clock: driven 0 or released to Z, never driven 1.
PS2_DAT  inout  1  open-collector data: driven 0 or released to Z, never driven 1.
received_data  output  8  last received byte; holds until the next good frame.
received_data_en  output  1  one-cycle pulse when received_data updates.
command_was_sent  output  1  transmit completed with ACK; held until send_command=0.
error_communication_timed_out  output  1  transmit aborted on timeout; held until send_command=0.

Behaviour:
- Reset state: all outputs 0, pins released (Z), FSM IDLE. Reset mid-frame aborts immediately and releases both pins.
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser. A falling edge is synced previous=1, current=0.
- Receive path (active only in IDLE/RX states):
  - A falling edge with DAT=0 starts a frame.
  - Sample DAT on each subsequent falling edge: 8 data bits LSB-first, then parity, then stop.
  - Good frame = odd parity correct and stop=1. On a good frame, received_data is loaded and received_data_en pulses in the cycle after the stop-bit edge.
  - A bad frame is dropped silently.
  - No clock edge for 2 ms mid-frame aborts the frame back to IDLE.
- Transmit path (FSM): IDLE -> INHIBIT -> START -> WAIT_DEV_CLK -> SHIFT -> WAIT_ACK -> DONE or TIMEOUT.
  - IDLE: if send_command=1 and no RX frame in progress, latch the_command, compute odd parity, go to INHIBIT. An RX frame in progress completes first.
  - INHIBIT: drive CLK low for INHIBIT_US cycles.
  - START: drive DAT low, release CLK.
  - WAIT_DEV_CLK: on the first device falling edge go to SHIFT. If DEV_CLK_TIMEOUT expires, go to TIMEOUT.
  - SHIFT: after each device falling edge, present the next bit: d0..d7, parity, then release DAT (stop=1). After the 10th edge post-start, go to WAIT_ACK. If TX_TIMEOUT (counted from SHIFT entry) expires, go to TIMEOUT.
  - WAIT_ACK: DAT sampled 0 on a falling edge, then CLK and DAT both high, gives DONE. If ACK_TIMEOUT expires, go to TIMEOUT.
  - DONE: command_was_sent=1. TIMEOUT: error_communication_timed_out=1 and both pins released. Each flag holds until send_command=0, then returns to IDLE.
  - A new request needs send_command to fall and then rise again.
- Device responses (e.g. 0xFA ACK byte) arrive through the normal receive path.
- Timers: one shared down-counter sized for the largest count, reloaded on each state entry.

Decomposition:
- Package ps2_pkg: tx-state enum; timing-count functions (us to cycles from CLK_FREQ_HZ); frame-length and parity helper constants.
- One natural sub-module: ps2_command_out (transmit FSM, timers, pin drive enables). The receive shifter and synchronisers stay in the top level.

Test Plan:
- Device sends 0xFA, parity 1, stop 1, at a 12.5 kHz clock -> received_data=0xFA, exactly one received_data_en pulse.
- Device sends 0x08 with wrong parity -> no received_data_en; received_data keeps its prior value.
- send_command=1, the_command=0xF4, model ACKs -> CLK held low >=5000 cycles; DAT bits 0,0,0,1,0,1,1,1,1, parity 0; command_was_sent=1 until send_command drops, then 0.
- send_command=1 with a model that never clocks -> error_communication_timed_out=1 after about 750000 cycles; pins Z; cleared when send_command=0.
- Model clocks the data but withholds ACK -> timeout flag set, command_was_sent stays 0.
- reset_n pulsed low mid-SHIFT -> pins Z and outputs 0 immediately; the next send completes normally.
